// File: rtl/wb_ram2_arbiter_if.sv
// Bus bundle for wb_ram2_arbiter: CPU-data and DMA master ports plus the RAM port-2 pins.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_ram2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_stb_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_data_i;
    logic [DATA_W-1:0] cpu_data_o;
    logic              cpu_ack_o;
    logic              cpu_err_o;

    logic              dma_stb_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [DATA_W-1:0] dma_data_i;
    logic [DATA_W-1:0] dma_data_o;
    logic              dma_ack_o;
    logic              dma_err_o;
    logic              dma_cyc_o;

    logic              ram2_stb_o;
    logic              ram2_ack_i;
    logic              ram2_we_o;
    logic [ADDR_W-1:0] ram2_addr_o;
    logic [DATA_W-1:0] ram2_data_o;
    logic [DATA_W-1:0] ram2_data_i;

    modport slave (
        input  cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_ack_o, cpu_err_o,
        input  dma_stb_i, dma_we_i, dma_addr_i, dma_data_i,
        output dma_data_o, dma_ack_o, dma_err_o, dma_cyc_o,
        output ram2_stb_o, ram2_we_o, ram2_addr_o, ram2_data_o,
        input  ram2_ack_i, ram2_data_i
    );

    modport master (
        output cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_ack_o, cpu_err_o,
        output dma_stb_i, dma_we_i, dma_addr_i, dma_data_i,
        input  dma_data_o, dma_ack_o, dma_err_o, dma_cyc_o,
        input  ram2_stb_o, ram2_we_o, ram2_addr_o, ram2_data_o,
        output ram2_ack_i, ram2_data_i
    );
endinterface

// File: rtl/wb_ram2_arbiter.sv
// Round-robin CPU/DMA arbiter for RAM port 2; one single transfer at a time, all outputs registered.
// Optional ack timeout with error response is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram2_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    wb_ram2_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT_C, GNT_D, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_dma, last_dma_nxt;
    logic              ram2_stb, ram2_stb_nxt;
    logic              ram2_we, ram2_we_nxt;
    logic [ADDR_W-1:0] ram2_addr, ram2_addr_nxt;
    logic [DATA_W-1:0] ram2_wdata, ram2_wdata_nxt;
    logic [DATA_W-1:0] cpu_rdata, cpu_rdata_nxt;
    logic [DATA_W-1:0] dma_rdata, dma_rdata_nxt;
    logic              cpu_ack, cpu_ack_nxt;
    logic              dma_ack, dma_ack_nxt;
    logic              cpu_err, cpu_err_nxt;
    logic              dma_err, dma_err_nxt;
    logic              dma_cyc, dma_cyc_nxt;
    logic              grant_c, grant_d, expire;

    // On a tie the master that did not win last time gets the port.
    assign grant_c = bus.cpu_stb_i && (!bus.dma_stb_i || last_dma);
    assign grant_d = bus.dma_stb_i && !grant_c;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Counts cycles spent in a grant state; zero whenever not granted.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !(state == GNT_C || state == GNT_D)) cnt <= '0;
        else                                                cnt <= cnt + 1'b1;
    end

    assign expire = (state == GNT_C || state == GNT_D) && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            last_dma   <= 1'b1;
            ram2_stb   <= 1'b0;
            ram2_we    <= 1'b0;
            ram2_addr  <= '0;
            ram2_wdata <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            dma_err    <= 1'b0;
            dma_cyc    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_dma   <= last_dma_nxt;
            ram2_stb   <= ram2_stb_nxt;
            ram2_we    <= ram2_we_nxt;
            ram2_addr  <= ram2_addr_nxt;
            ram2_wdata <= ram2_wdata_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            dma_rdata  <= dma_rdata_nxt;
            cpu_ack    <= cpu_ack_nxt;
            dma_ack    <= dma_ack_nxt;
            cpu_err    <= cpu_err_nxt;
            dma_err    <= dma_err_nxt;
            dma_cyc    <= dma_cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (grant_c) state_nxt = GNT_C;
                         else if (grant_d) state_nxt = GNT_D;
            GNT_C,
            GNT_D:       if (bus.ram2_ack_i || expire) state_nxt = RESP;
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Registers hold by default; the ack input only matters in a grant state.
    always_comb begin
        last_dma_nxt   = last_dma;
        ram2_stb_nxt   = ram2_stb;
        ram2_we_nxt    = ram2_we;
        ram2_addr_nxt  = ram2_addr;
        ram2_wdata_nxt = ram2_wdata;
        cpu_rdata_nxt  = cpu_rdata;
        dma_rdata_nxt  = dma_rdata;
        cpu_ack_nxt    = cpu_ack;
        dma_ack_nxt    = dma_ack;
        cpu_err_nxt    = cpu_err;
        dma_err_nxt    = dma_err;
        dma_cyc_nxt    = dma_cyc;
        case (state)
            IDLE: begin
                if (grant_c || grant_d) begin
                    ram2_stb_nxt   = 1'b1;
                    ram2_we_nxt    = grant_c ? bus.cpu_we_i   : bus.dma_we_i;
                    ram2_addr_nxt  = grant_c ? bus.cpu_addr_i : bus.dma_addr_i;
                    ram2_wdata_nxt = grant_c ? bus.cpu_data_i : bus.dma_data_i;
                    last_dma_nxt   = grant_d;
                    dma_cyc_nxt    = grant_d;
                end
            end
            GNT_C: begin
                if (bus.ram2_ack_i) begin
                    ram2_stb_nxt  = 1'b0;
                    cpu_rdata_nxt = bus.ram2_data_i;
                    cpu_ack_nxt   = 1'b1;
                end else if (expire) begin
                    ram2_stb_nxt  = 1'b0;
                    cpu_err_nxt   = 1'b1;
                end
            end
            GNT_D: begin
                if (bus.ram2_ack_i) begin
                    ram2_stb_nxt  = 1'b0;
                    dma_rdata_nxt = bus.ram2_data_i;
                    dma_ack_nxt   = 1'b1;
                end else if (expire) begin
                    ram2_stb_nxt  = 1'b0;
                    dma_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                cpu_ack_nxt = 1'b0;
                dma_ack_nxt = 1'b0;
                cpu_err_nxt = 1'b0;
                dma_err_nxt = 1'b0;
                dma_cyc_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.ram2_stb_o  = ram2_stb;
    assign bus.ram2_we_o   = ram2_we;
    assign bus.ram2_addr_o = ram2_addr;
    assign bus.ram2_data_o = ram2_wdata;
    assign bus.cpu_data_o  = cpu_rdata;
    assign bus.dma_data_o  = dma_rdata;
    assign bus.cpu_ack_o   = cpu_ack;
    assign bus.dma_ack_o   = dma_ack;
    assign bus.cpu_err_o   = cpu_err;
    assign bus.dma_err_o   = dma_err;
    assign bus.dma_cyc_o   = dma_cyc;
endmodule
